// File: rtl/shift_arbiter_if.sv
// Request/response bundle for the shared barrel-shift arbiter.
// slave is the arbiter side; master is the issue/consumer side.
interface shift_arbiter_if #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
);
  logic               req0_valid;
  logic               req0_ready;
  logic [XLEN-1:0]    req0_src;
  logic               req0_direction;
  logic               req0_sign;
  logic [SHAMT_W-1:0] req0_num;

  logic               req1_valid;
  logic               req1_ready;
  logic [XLEN-1:0]    req1_src;
  logic               req1_direction;
  logic               req1_sign;
  logic [SHAMT_W-1:0] req1_num;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [XLEN-1:0]    rsp_data;

  modport slave (
    input  req0_valid, req0_src, req0_direction, req0_sign, req0_num,
    input  req1_valid, req1_src, req1_direction, req1_sign, req1_num,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req0_valid, req0_src, req0_direction, req0_sign, req0_num,
    output req1_valid, req1_src, req1_direction, req1_sign, req1_num,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of one shared barrel shifter.
// The granted operation is shifted combinationally and lands in a single
// registered response stage tagged with the requester id. The response
// stage may drain and refill in the same cycle, so throughput is 1 op/cycle.
module shift_arbiter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input logic             clk,
  input logic             rst,
  shift_arbiter_if.slave  bus
);

  logic [1:0]         req_valid;
  logic [1:0]         grant;
  logic               can_accept;
  logic               xfer;
  logic               sel;
  logic               prio;

  logic [XLEN-1:0]    op_src;
  logic               op_dir;
  logic               op_sign;
  logic [SHAMT_W-1:0] op_num;
  logic [XLEN-1:0]    result;

  logic               rsp_valid_q;
  logic               rsp_id_q;
  logic [XLEN-1:0]    rsp_data_q;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // Grant: a lone requester wins outright; on contention prio decides.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Readies are held low during reset so nothing is consumed then.
  assign bus.req0_ready = !rst && grant[0] && can_accept;
  assign bus.req1_ready = !rst && grant[1] && can_accept;
  assign xfer           = bus.req0_ready || bus.req1_ready;
  assign sel            = grant[1];

  // Operand mux feeding the single shared shifter.
  always_comb begin
    op_src  = bus.req0_src;
    op_dir  = bus.req0_direction;
    op_sign = bus.req0_sign;
    op_num  = bus.req0_num;
    if (sel) begin
      op_src  = bus.req1_src;
      op_dir  = bus.req1_direction;
      op_sign = bus.req1_sign;
      op_num  = bus.req1_num;
    end
  end

  // Barrel shift: left zero-fill, or right with sign or zero fill.
  always_comb begin
    result = op_src;
    if (op_dir)
      result = op_src << op_num;
    else if (op_sign)
      result = $signed(op_src) >>> op_num;
    else
      result = op_src >> op_num;
  end

  // Response register and round-robin pointer; the pointer only moves on an
  // accepted transfer, so a stalled grant never changes who is favoured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      prio        <= 1'b0;
    end else if (xfer) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= sel;
      rsp_data_q  <= result;
      prio        <= ~sel;
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_shift_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  shift_arbiter_if #(.XLEN(32)) bus ();

  shift_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference shift from plain arithmetic: multiply/divide by 2**num.
  function automatic logic [31:0] ref_shift(input logic [31:0] s, input logic dir,
                                            input logic sg, input logic [4:0] n);
    logic [63:0] p;
    logic [63:0] prod;
    logic [31:0] r;
    p = 64'd1 << n;
    if (dir) begin
      prod = {32'd0, s} * p;
      r    = prod[31:0];
    end else begin
      r = s / p[31:0];
      if (sg && s >= 32'h8000_0000)
        r = r | ~(32'hFFFF_FFFF / p[31:0]);
    end
    return r;
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] s,
                         input logic dir, input logic sg, input logic [4:0] num);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_src = s; bus.req0_direction = dir;
      bus.req0_sign = sg; bus.req0_num = num;
    end else begin
      bus.req1_valid = v; bus.req1_src = s; bus.req1_direction = dir;
      bus.req1_sign = sg; bus.req1_num = num;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h1, 1'b1, 1'b0, 5'd1);
    set_req(1, 1'b1, 32'h2, 1'b1, 1'b0, 5'd1);
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%b exp=0", bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_readies got=%b exp=00", {bus.req1_ready, bus.req0_ready}); end
    do_reset();
  endtask

  task automatic test_left();
    set_req(0, 1'b1, 32'h0000_00F1, 1'b1, 1'b0, 5'd4);
    @(negedge clk);
    n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL left_ready got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL left_valid got=%b exp=1", bus.rsp_valid); end
    n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL left_id got=%b exp=0", bus.rsp_id); end
    n_checks++; if (bus.rsp_data !== 32'h0000_0F10) begin n_fail++; $display("FAIL left_data got=%h exp=00000f10", bus.rsp_data); end
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got=%b exp=0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_data !== 32'h0000_0F10) begin n_fail++; $display("FAIL drain_hold got=%h exp=00000f10", bus.rsp_data); end
  endtask

  task automatic test_right();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'hFFFF_FFFF;
    exp_d[1] = 32'h0000_0001;
    for (int i = 0; i < 2; i++) begin
      set_req(1, 1'b1, 32'h8000_0000, 1'b0, (i == 0), 5'd31);
      @(negedge clk);
      n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin n_fail++; $display("FAIL right_ready[%0d] got=%b exp=10", i, {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      set_req(1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
      n_checks++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL right_id[%0d] got=%b exp=1", i, bus.rsp_id); end
      n_checks++; if (bus.rsp_data !== exp_d[i]) begin n_fail++; $display("FAIL right_data[%0d] got=%h exp=%h", i, bus.rsp_data, exp_d[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    logic [31:0] exp_d [2];
    exp_d[0] = 32'h0000_0002;
    exp_d[1] = 32'h0000_0010;
    do_reset();
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 5'd1);
    set_req(1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.req1_ready, bus.req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL fair_ready[%0d] got=%b", i, {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid[%0d] got=%b exp=1", i, bus.rsp_valid); end
      n_checks++; if (bus.rsp_id !== 1'(i % 2)) begin n_fail++; $display("FAIL fair_id[%0d] got=%b exp=%0d", i, bus.rsp_id, i % 2); end
      n_checks++; if (bus.rsp_data !== exp_d[i % 2]) begin n_fail++; $display("FAIL fair_data[%0d] got=%h exp=%h", i, bus.rsp_data, exp_d[i % 2]); end
    end
  endtask

  // Continues from test_fairness: response from req1 held, req0 favoured.
  task automatic test_backpressure();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready[%0d] got=%b exp=00", i, {bus.req1_ready, bus.req0_ready}); end
      @(posedge clk); #1;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_data !== 32'h10) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%b/%b/%h exp=1/1/00000010", i, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    n_checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'h2) begin n_fail++; $display("FAIL bp_release_rsp got=%b/%h exp=0/00000002", bus.rsp_id, bus.rsp_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_num_edges();
    logic [31:0] srcs [4];
    logic        dirs [4];
    logic        sgns [4];
    logic [4:0]  nums [4];
    logic [31:0] exps [4];
    srcs[0] = 32'hDEAD_BEEF; dirs[0] = 1'b1; sgns[0] = 1'b0; nums[0] = 5'd0;  exps[0] = 32'hDEAD_BEEF;
    srcs[1] = 32'hDEAD_BEEF; dirs[1] = 1'b0; sgns[1] = 1'b1; nums[1] = 5'd0;  exps[1] = 32'hDEAD_BEEF;
    srcs[2] = 32'hDEAD_BEEF; dirs[2] = 1'b0; sgns[2] = 1'b0; nums[2] = 5'd0;  exps[2] = 32'hDEAD_BEEF;
    srcs[3] = 32'h0000_0003; dirs[3] = 1'b1; sgns[3] = 1'b0; nums[3] = 5'd31; exps[3] = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, srcs[i], dirs[i], sgns[i], nums[i]);
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exps[i]) begin n_fail++; $display("FAIL edge_data[%0d] got=%b/%h exp=1/%h", i, bus.rsp_valid, bus.rsp_data, exps[i]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'h5, 1'b1, 1'b0, 5'd0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b exp=1", bus.rsp_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_drop got=%b exp=0", bus.rsp_valid); end
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_edge got=%b exp=0", bus.rsp_valid); end
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h7, 1'b1, 1'b0, 5'd1);
    set_req(1, 1'b1, 32'h7, 1'b0, 1'b0, 5'd1);
    @(negedge clk);
    n_checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    n_checks++; if (bus.rsp_id !== 1'b0 || bus.rsp_data !== 32'hE) begin n_fail++; $display("FAIL mid_first_rsp got=%b/%h exp=0/0000000e", bus.rsp_id, bus.rsp_data); end
    @(posedge clk); #1;
  endtask

  // Random traffic; requesters hold operands until accepted.
  task automatic test_random();
    logic        m_prio, m_valid, m_id;
    logic [31:0] m_data;
    logic        pend [2];
    logic [31:0] s [2];
    logic        d [2], g [2];
    logic [4:0]  n [2];
    logic        win, can, e0, e1;
    do_reset();
    m_prio = 1'b0; m_valid = 1'b0; m_id = 1'b0; m_data = 32'd0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 9) < 6) begin
          pend[r] = 1'b1;
          s[r] = $urandom; d[r] = 1'($urandom); g[r] = 1'($urandom);
          n[r] = ($urandom_range(0, 3) == 0) ? 5'(($urandom_range(0, 1)) * 31) : 5'($urandom);
        end
        set_req(r, pend[r], s[r], d[r], g[r], n[r]);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      win = (pend[0] && pend[1]) ? m_prio : pend[1];
      can = !m_valid || bus.rsp_ready;
      e0  = pend[0] && can && !win;
      e1  = pend[1] && can && win;
      @(negedge clk);
      n_checks++; if ({bus.req1_ready, bus.req0_ready} !== {e1, e0}) begin n_fail++; $display("FAIL rand_ready[%0d] got=%b exp=%b", c, {bus.req1_ready, bus.req0_ready}, {e1, e0}); end
      @(posedge clk); #1;
      if (e0 || e1) begin
        m_valid = 1'b1; m_id = win;
        m_data = ref_shift(s[win], d[win], g[win], n[win]);
        m_prio = !win; pend[win] = 1'b0;
      end else if (bus.rsp_ready) begin
        m_valid = 1'b0;
      end
      n_checks++; if (bus.rsp_valid !== m_valid || bus.rsp_id !== m_id || bus.rsp_data !== m_data) begin
        n_fail++; $display("FAIL rand_rsp[%0d] got=%b/%b/%h exp=%b/%b/%h", c, bus.rsp_valid, bus.rsp_id, bus.rsp_data, m_valid, m_id, m_data);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 1'b0, 5'd0);
    #1;
    test_reset();
    test_left();
    test_right();
    test_fairness();
    test_backpressure();
    test_num_edges();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
